// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: walks C=A*B element by element in row-major
// order, issuing A/B memory reads for each inner-product term, steering the
// external MAC, and presenting each finished element with a valid/ready
// handshake. A run starts on a fresh rising level of matrices_loaded.
module matmul_ctrl #(
  parameter  int M           = 7,
  parameter  int N           = 9,
  parameter  int MAXK        = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N),
  localparam int M_BITS      = $clog2(M),
  localparam int N_BITS      = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  output logic                   mac_en,
  output logic                   mac_init,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [M_BITS-1:0]      res_m,
  output logic [N_BITS-1:0]      res_n,
  output logic                   compute_finished
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT_OUT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic [K_BITS-1:0]      k_reg_q, k_reg_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [M_BITS-1:0]      m_q, m_d;
  logic [N_BITS-1:0]      n_q, n_d;

  logic [A_ADDR_BITS-1:0] a_addr_q, a_addr_d;
  logic [B_ADDR_BITS-1:0] b_addr_q, b_addr_d;
  logic                   mac_en_q, mac_en_d;
  logic                   mac_init_q, mac_init_d;
  logic                   res_valid_q, res_valid_d;
  logic                   finished_q, finished_d;

  // Next-state, counter and registered-output computation.
  // Outputs are derived from the *next* state so that the registered copy
  // lines up with the state it describes (addresses valid during ISSUE).
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    k_reg_d    = k_reg_q;
    k_d        = k_q;
    m_d        = m_q;
    n_d        = n_q;

    // A low level of matrices_loaded re-arms the start detector.
    if (!matrices_loaded) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && matrices_loaded) begin
          armed_d = 1'b0;
          if (K != '0) begin
            k_reg_d = K;
            m_d     = '0;
            n_d     = '0;
            k_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        k_d = k_q + K_BITS'(1);
        if (k_q == k_reg_q - K_BITS'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (res_ready) begin
          if (m_q == M_BITS'(M - 1) && n_q == N_BITS'(N - 1)) begin
            state_d = DONE;
          end else begin
            if (n_q == N_BITS'(N - 1)) begin
              n_d = '0;
              m_d = m_q + M_BITS'(1);
            end else begin
              n_d = n_q + N_BITS'(1);
            end
            k_d     = '0;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operands are widened to the address width before multiplying so the
    // product cannot wrap for any K up to MAXK.
    a_addr_d = '0;
    b_addr_d = '0;
    if (state_d == ISSUE) begin
      a_addr_d = A_ADDR_BITS'(m_d) * A_ADDR_BITS'(k_reg_d) + A_ADDR_BITS'(k_d);
      b_addr_d = B_ADDR_BITS'(k_d) * B_ADDR_BITS'(N) + B_ADDR_BITS'(n_d);
    end

    // Read data returns one cycle after the address, so the MAC strobes
    // are the issue flags delayed by one register stage.
    mac_en_d    = (state_q == ISSUE);
    mac_init_d  = (state_q == ISSUE) && (k_q == '0);
    res_valid_d = (state_d == WAIT_OUT);
    finished_d  = (state_d == DONE);
  end

  // State, counters and output registers; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      k_reg_q     <= '0;
      k_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      mac_en_q    <= 1'b0;
      mac_init_q  <= 1'b0;
      res_valid_q <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      k_reg_q     <= k_reg_d;
      k_q         <= k_d;
      m_q         <= m_d;
      n_q         <= n_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      mac_en_q    <= mac_en_d;
      mac_init_q  <= mac_init_d;
      res_valid_q <= res_valid_d;
      finished_q  <= finished_d;
    end
  end

  assign A_read_addr      = a_addr_q;
  assign B_read_addr      = b_addr_q;
  assign mac_en           = mac_en_q;
  assign mac_init         = mac_init_q;
  assign res_valid        = res_valid_q;
  assign res_m            = m_q;
  assign res_n            = n_q;
  assign compute_finished = finished_q;

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter M, default 7, meaning rows of A and of C.
REQ-002 SHALL have parameter N, default 9, meaning columns of B and of C.
REQ-003 SHALL have parameter MAXK, default 8, meaning the largest supported inner dimension.
REQ-004 SHALL derive localparams K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N), M_BITS=$clog2(M), N_BITS=$clog2(N).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port matrices_loaded, input, 1 bit: A and B memories hold complete matrices.
REQ-008 SHALL have port K, input, K_BITS: inner dimension, valid while matrices_loaded=1.
REQ-009 SHALL have port A_read_addr, output, A_ADDR_BITS: A memory read address; data returns one cycle later.
REQ-010 SHALL have port B_read_addr, output, B_ADDR_BITS: B memory read address; data returns one cycle later.
REQ-011 SHALL have port mac_en, output, 1 bit: A_data/B_data product is valid this cycle and is accumulated.
REQ-012 SHALL have port mac_init, output, 1 bit: with mac_en, load the product and discard the prior sum.
REQ-013 SHALL have port res_valid, output, 1 bit: the C element in the accumulator is final.
REQ-014 SHALL have port res_ready, input, 1 bit: downstream accepts the result; transfer when res_valid and res_ready are both 1.
REQ-015 SHALL have port res_m, output, M_BITS: row index of the presented result.
REQ-016 SHALL have port res_n, output, N_BITS: column index of the presented result.
REQ-017 SHALL have port compute_finished, output, 1 bit: one-cycle pulse; all M*N results accepted.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, WAIT_OUT, DONE.
REQ-019 IDLE: if armed=1, matrices_loaded=1 and K!=0, SHALL latch K into k_reg, clear m, n and k, and go to ISSUE.
REQ-020 IDLE: if armed=1, matrices_loaded=1 and K=0, SHALL go directly to DONE and produce no results.
REQ-021 armed SHALL be 1 after reset, clear on leaving IDLE, and set only when matrices_loaded=0 is sampled; a stale high level after DONE therefore never restarts the block.
REQ-022 ISSUE: SHALL drive A_read_addr=m*k_reg+k and B_read_addr=k*N+n, row-major.
REQ-023 ISSUE: SHALL increment k every cycle; when k=k_reg-1, SHALL go to DRAIN.
REQ-024 mac_en SHALL be the issue flag registered once: high for exactly k_reg cycles, starting one cycle after the first issue.
REQ-025 mac_init SHALL be the (k=0) flag registered once, so it coincides with the first mac_en of each element.
REQ-026 DRAIN: SHALL last one cycle; this is the last mac_en cycle; SHALL then go to WAIT_OUT.
REQ-027 WAIT_OUT: SHALL hold res_valid=1 with stable res_m=m and res_n=n until res_ready=1.
REQ-028 On acceptance, if m=M-1 and n=N-1, SHALL go to DONE.
REQ-029 On acceptance otherwise, SHALL set n=n+1, or n=0 and m=m+1 when n=N-1, then clear k and go to ISSUE.
REQ-030 DONE: SHALL assert compute_finished for one cycle, then go to IDLE.
REQ-031 Outside ISSUE, addresses SHALL be 0, and mac_en, res_valid and compute_finished SHALL be 0 except where stated above.
REQ-032 Changes to K or matrices_loaded after the start SHALL be ignored until IDLE.
REQ-033 Address products SHALL be computed at full width; no overflow for K<=MAXK.
REQ-034 Timing with matrices_loaded sampled in cycle c0 and res_ready held 1:
- first issue in cycle c0+1;
- first res_valid in cycle c0+k_reg+2;
- each element takes k_reg+2 cycles;
- compute_finished in cycle c0+M*N*(k_reg+2)+1.
REQ-035 res_ready=0 SHALL stall only WAIT_OUT; nothing further is issued while stalled.

Reset
REQ-036 reset=0 SHALL asynchronously force IDLE, armed=1, m=n=k=0 and k_reg=0.
REQ-037 reset=0 SHALL asynchronously force all outputs to 0, including mid-operation; the block resumes only through REQ-019.

Verification
REQ-038 M=7, N=9, K=8, res_ready always 1, matrices_loaded rises at c0 -> 63 results in order (0,0),(0,1)..(6,8); compute_finished at c0+631; mac_en asserted 504 cycles total.
REQ-039 K=3, element (2,4) -> issued A addresses 6,7,8 and B addresses 4,13,22; mac_init with the first mac_en only.
REQ-040 res_ready held 0 for 5 cycles on element (0,0) -> res_valid, res_m and res_n stable throughout; no mac_en; issue resumes the cycle after acceptance.
REQ-041 matrices_loaded held 1 for 3 cycles after compute_finished -> stays in IDLE; restarts only after a low then high.
REQ-042 K=0 -> compute_finished one cycle after start; res_valid never asserted.
REQ-043 reset pulsed low during ISSUE of element (3,2) -> all outputs 0 immediately; a full run after restart matches REQ-038.
